// File: rtl/btb_pkg.sv
// Branch target buffer shared definitions: geometry and 2-bit counter encodings.
// Build switch: define BTB_STATS_EN to add lookup/hit/mispredict counters.
package btb_pkg;

    localparam int BTB_ENTRIES = 64;
    localparam int BTB_INDEX_W = 6;
    localparam int BTB_TAG_W   = 8;

    // PC bit positions of the index and tag fields.
    localparam int BTB_IDX_HI = BTB_INDEX_W + 1;
    localparam int BTB_TAG_LO = BTB_INDEX_W + 2;
    localparam int BTB_TAG_HI = BTB_INDEX_W + BTB_TAG_W + 1;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/btb_if.sv
// BTB port bundle: IF lookup, ID install and EX training.
// Stats outputs exist only when BTB_STATS_EN is defined.
interface btb_if;

    logic        if_re_i;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        b_we_i;
    logic [31:0] b_waddr_i;
    logic [31:0] b_wtarget_i;
    logic        upd_we_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic        upd_mispredict_i;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookup_o;
    logic [31:0] stat_hit_o;
    logic [31:0] stat_mispred_o;
`endif

    modport master (
        output if_re_i, if_pc_i,
        output b_we_i, b_waddr_i, b_wtarget_i,
        output upd_we_i, upd_pc_i, upd_taken_i, upd_mispredict_i,
        input  pred_taken_o, pred_target_o
`ifdef BTB_STATS_EN
        , input stat_lookup_o, stat_hit_o, stat_mispred_o
`endif
    );

    modport slave (
        input  if_re_i, if_pc_i,
        input  b_we_i, b_waddr_i, b_wtarget_i,
        input  upd_we_i, upd_pc_i, upd_taken_i, upd_mispredict_i,
        output pred_taken_o, pred_target_o
`ifdef BTB_STATS_EN
        , output stat_lookup_o, stat_hit_o, stat_mispred_o
`endif
    );

endinterface

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating counter next-state.
module btb_sat_ctr
    import btb_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (ctr_i)
            SNT: ctr_o = taken_i ? WNT : SNT;
            WNT: ctr_o = taken_i ? WT  : SNT;
            WT:  ctr_o = taken_i ? ST  : WNT;
            ST:  ctr_o = taken_i ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/btb.sv
// Direct-mapped tagged branch target buffer with 2-bit direction counters.
// Define BTB_STATS_EN to add the lookup/hit/mispredict statistics counters.
module btb
    import btb_pkg::*;
(
    input logic  clk,
    input logic  rst,
    input logic  rdy,
    btb_if.slave bus
);

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [BTB_TAG_W-1:0]   tag_q [BTB_ENTRIES];
    logic [31:0]            tgt_q [BTB_ENTRIES];
    ctr_e                   ctr_q [BTB_ENTRIES];

    logic [BTB_INDEX_W-1:0] r_idx, w_idx, u_idx;
    logic [BTB_TAG_W-1:0]   r_tag, w_tag, u_tag;
    logic                   hit, w_hit, u_hit, u_drop;
    ctr_e                   u_next;

    assign r_idx = bus.if_pc_i[BTB_IDX_HI:2];
    assign w_idx = bus.b_waddr_i[BTB_IDX_HI:2];
    assign u_idx = bus.upd_pc_i[BTB_IDX_HI:2];
    assign r_tag = bus.if_pc_i[BTB_TAG_HI:BTB_TAG_LO];
    assign w_tag = bus.b_waddr_i[BTB_TAG_HI:BTB_TAG_LO];
    assign u_tag = bus.upd_pc_i[BTB_TAG_HI:BTB_TAG_LO];

    assign hit   = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign bus.pred_taken_o  = hit && ctr_q[r_idx][1];
    assign bus.pred_target_o = bus.pred_taken_o ? tgt_q[r_idx]
                                                : bus.if_pc_i + 32'd4;

    // A fresh allocation on the trained slot wins over the train.
    assign u_drop = bus.b_we_i && !w_hit && (w_idx == u_idx);

    btb_sat_ctr u_sat (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (bus.upd_taken_i),
        .ctr_o   (u_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (rdy) begin
            if (bus.b_we_i) begin
                valid_q[w_idx] <= 1'b1;
                tag_q[w_idx]   <= w_tag;
                tgt_q[w_idx]   <= bus.b_wtarget_i;
                if (!w_hit) begin
                    ctr_q[w_idx] <= WT;
                end
            end
            if (bus.upd_we_i && u_hit && !u_drop) begin
                ctr_q[u_idx] <= u_next;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] n_look, n_hit, n_misp;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_look <= '0;
            n_hit  <= '0;
            n_misp <= '0;
        end else if (rdy) begin
            if (bus.if_re_i) begin
                n_look <= n_look + 32'd1;
            end
            if (bus.if_re_i && hit) begin
                n_hit <= n_hit + 32'd1;
            end
            if (bus.upd_we_i && bus.upd_mispredict_i) begin
                n_misp <= n_misp + 32'd1;
            end
        end
    end

    assign bus.stat_lookup_o  = n_look;
    assign bus.stat_hit_o     = n_hit;
    assign bus.stat_mispred_o = n_misp;
`else
    logic unused_stats;
    assign unused_stats = bus.if_re_i ^ bus.upd_mispredict_i;
`endif

    logic unused_pc;
    assign unused_pc = ^{bus.b_waddr_i[31:BTB_TAG_HI+1],
                         bus.b_waddr_i[1:0],
                         bus.upd_pc_i[31:BTB_TAG_HI+1],
                         bus.upd_pc_i[1:0]};

endmodule

// File: tb/tb_btb.sv
// Self-checking bench for btb: per-cycle model compare plus directed literals.
// Stats checks are compiled in when BTB_STATS_EN is defined.
module tb_btb;
    import btb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    btb_if bus();

    btb dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one slot per index holding the installed branch's tag and target.
    typedef struct {
        bit          v;
        int          tag;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    ent_t        m [BTB_ENTRIES];
    logic [31:0] s_look, s_hit, s_misp;
    bit          model_ok = 0;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % BTB_ENTRIES);
    endfunction

    function automatic int mtag(input logic [31:0] pc);
        return int'((pc >> (BTB_INDEX_W + 2)) % (1 << BTB_TAG_W));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m[midx(pc)].v && (m[midx(pc)].tag == mtag(pc));
    endfunction

    // Train first, then install: an allocation naturally overwrites the train.
    always @(posedge clk) begin : model
        int ui, wi;
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                m[i].v = 0;
                m[i].ctr = 1;
            end
            s_look = 0;
            s_hit = 0;
            s_misp = 0;
            model_ok = 1;
        end else if (rdy && model_ok) begin
            if (bus.if_re_i) begin
                s_look = s_look + 1;
                if (m_hit(bus.if_pc_i)) s_hit = s_hit + 1;
            end
            if (bus.upd_we_i && bus.upd_mispredict_i) s_misp = s_misp + 1;
            ui = midx(bus.upd_pc_i);
            if (bus.upd_we_i && m_hit(bus.upd_pc_i)) begin
                if (bus.upd_taken_i)
                    m[ui].ctr = (m[ui].ctr + 1 > 3) ? 3 : m[ui].ctr + 1;
                else
                    m[ui].ctr = (m[ui].ctr - 1 < 0) ? 0 : m[ui].ctr - 1;
            end
            wi = midx(bus.b_waddr_i);
            if (bus.b_we_i) begin
                if (m_hit(bus.b_waddr_i)) begin
                    m[wi].tgt = bus.b_wtarget_i;
                end else begin
                    m[wi] = '{1'b1, mtag(bus.b_waddr_i), bus.b_wtarget_i, 2};
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic        et;
        logic [31:0] etg;
        if (model_ok) begin
            et  = m_hit(bus.if_pc_i) && (m[midx(bus.if_pc_i)].ctr >= 2);
            etg = et ? m[midx(bus.if_pc_i)].tgt : bus.if_pc_i + 32'd4;
            chk("model_taken", {31'd0, bus.pred_taken_o}, {31'd0, et});
            chk("model_target", bus.pred_target_o, etg);
`ifdef BTB_STATS_EN
            chk("model_stat_lookup", bus.stat_lookup_o, s_look);
            chk("model_stat_hit", bus.stat_hit_o, s_hit);
            chk("model_stat_mispred", bus.stat_mispred_o, s_misp);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic look(input string nm, input logic [31:0] pc,
                        input logic et, input logic [31:0] etg);
        bus.if_pc_i = pc;
        #1;
        chk({nm, "_taken"}, {31'd0, bus.pred_taken_o}, {31'd0, et});
        chk({nm, "_target"}, bus.pred_target_o, etg);
    endtask

    task automatic inst(input logic [31:0] pc, input logic [31:0] tg);
        bus.b_we_i = 1'b1;
        bus.b_waddr_i = pc;
        bus.b_wtarget_i = tg;
    endtask

    task automatic train(input logic [31:0] pc, input logic tk);
        bus.upd_we_i = 1'b1;
        bus.upd_pc_i = pc;
        bus.upd_taken_i = tk;
    endtask

    task automatic idle();
        bus.b_we_i = 1'b0;
        bus.upd_we_i = 1'b0;
        bus.upd_mispredict_i = 1'b0;
        bus.if_re_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.if_pc_i = 32'h0;
        bus.b_waddr_i = 32'h0;
        bus.b_wtarget_i = 32'h0;
        bus.upd_pc_i = 32'h0;
        bus.upd_taken_i = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        look("rst_lookup", 32'h1000, 1'b0, 32'h1004);

        inst(32'h1000, 32'h0F00);
        look("no_bypass", 32'h1000, 1'b0, 32'h1004);
        tick();
        idle();
        look("installed", 32'h1000, 1'b1, 32'h0F00);
        look("alias_tag", 32'h1100, 1'b0, 32'h1104);

        train(32'h1000, 1'b0);
        tick();
        look("nt1", 32'h1000, 1'b0, 32'h1004);
        tick();
        look("nt2", 32'h1000, 1'b0, 32'h1004);

        train(32'h1000, 1'b1);
        tick();
        look("t1", 32'h1000, 1'b0, 32'h1004);
        tick();
        look("t2", 32'h1000, 1'b1, 32'h0F00);
        tick();
        tick();
        tick();
        look("t5_sat", 32'h1000, 1'b1, 32'h0F00);
        train(32'h1000, 1'b0);
        tick();
        look("sat_dn1", 32'h1000, 1'b1, 32'h0F00);
        tick();
        look("sat_dn2", 32'h1000, 1'b0, 32'h1004);
        idle();

        // Held refresh must keep the trained counter at 01.
        inst(32'h1000, 32'h0F40);
        tick();
        tick();
        tick();
        idle();
        look("refresh_keep", 32'h1000, 1'b0, 32'h1004);
        train(32'h1000, 1'b1);
        tick();
        idle();
        look("refresh_tgt", 32'h1000, 1'b1, 32'h0F40);

        inst(32'h2000, 32'h3000);
        tick();
        idle();
        train(32'h2000, 1'b0);
        tick();
        idle();
        look("x2000_wnt", 32'h2000, 1'b0, 32'h2004);
        look("evicted", 32'h1000, 1'b0, 32'h1004);

        inst(32'h2000, 32'h3400);
        train(32'h2000, 1'b1);
        tick();
        idle();
        look("same_tag", 32'h2000, 1'b1, 32'h3400);
        train(32'h2000, 1'b0);
        tick();
        idle();
        look("same_tag_ctr", 32'h2000, 1'b0, 32'h2004);

        train(32'h2000, 1'b1);
        tick();
        idle();
        look("x2000_wt", 32'h2000, 1'b1, 32'h3400);
        inst(32'h2100, 32'h5000);
        train(32'h2000, 1'b1);
        tick();
        idle();
        look("new_tag", 32'h2100, 1'b1, 32'h5000);
        look("old_gone", 32'h2000, 1'b0, 32'h2004);
        train(32'h2100, 1'b0);
        tick();
        idle();
        look("new_tag_ctr", 32'h2100, 1'b0, 32'h2104);

        inst(32'h1004, 32'h7000);
        train(32'h2100, 1'b1);
        tick();
        idle();
        look("diff_idx_w", 32'h1004, 1'b1, 32'h7000);
        look("diff_idx_u", 32'h2100, 1'b1, 32'h5000);

        rdy = 1'b0;
        inst(32'h2100, 32'h6000);
        train(32'h2100, 1'b0);
        tick();
        look("frozen_live", 32'h2100, 1'b1, 32'h5000);
        inst(32'h1008, 32'h6100);
        tick();
        rdy = 1'b1;
        idle();
        look("frozen", 32'h2100, 1'b1, 32'h5000);
        look("frozen_alloc", 32'h1008, 1'b0, 32'h100C);

        rst = 1'b1;
        inst(32'h3000, 32'h8000);
        tick();
        rst = 1'b0;
        idle();
        look("rst_mid_a", 32'h2100, 1'b0, 32'h2104);
        look("rst_mid_b", 32'h1004, 1'b0, 32'h1008);
        look("rst_mid_w", 32'h3000, 1'b0, 32'h3004);

`ifdef BTB_STATS_EN
        inst(32'h1000, 32'h0F00);
        tick();
        idle();
        rdy = 1'b0;
        bus.if_re_i = 1'b1;
        bus.if_pc_i = 32'h1000;
        bus.upd_we_i = 1'b1;
        bus.upd_mispredict_i = 1'b1;
        bus.upd_pc_i = 32'h4000;
        tick();
        rdy = 1'b1;
        idle();
        bus.if_re_i = 1'b1;
        bus.if_pc_i = 32'h1000;
        tick();
        tick();
        tick();
        bus.if_pc_i = 32'h1100;
        tick();
        bus.if_pc_i = 32'h1200;
        tick();
        idle();
        bus.upd_we_i = 1'b1;
        bus.upd_mispredict_i = 1'b1;
        bus.upd_pc_i = 32'h4000;
        bus.upd_taken_i = 1'b0;
        tick();
        tick();
        idle();
        chk("stat_lookup", bus.stat_lookup_o, 32'd5);
        chk("stat_hit", bus.stat_hit_o, 32'd3);
        chk("stat_mispred", bus.stat_mispred_o, 32'd2);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
